muldiv_unit: RTL

Iterative multiply/divide execution unit that consumes the 5-bit ALU control codes for mult (10001), multu (10010), div (10011) and divu (10100), and owns the HI/LO register pair. It sits in the execute stage beside the single-cycle ALU. It asserts `busy` so the hazard unit stalls the pipeline while an operation iterates, and it provides HI/LO read data plus mthi/mtlo write ports.

---
 rtl/muldiv_unit.sv | 270 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide unit that owns the HI/LO pair.
// Shift-add multiply and restoring divide work on operand magnitudes for
// WIDTH cycles. The sign fix-up is applied on the edge that finishes the
// last iteration, then a one-cycle DONE state announces the commit.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [4:0]       alucontrol,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] hi_wdata,
    input  logic [WIDTH-1:0] lo_wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [4:0] OP_MULT  = 5'b10001;
    localparam logic [4:0] OP_MULTU = 5'b10010;
    localparam logic [4:0] OP_DIV   = 5'b10011;
    localparam logic [4:0] OP_DIVU  = 5'b10100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Two's-complement negate of a WIDTH-bit value.
    function automatic logic [WIDTH-1:0] neg_fn(input logic [WIDTH-1:0] v);
        neg_fn = ~v + WIDTH'(1'b1);
    endfunction

    // Two's-complement negate of a 2*WIDTH-bit value.
    function automatic logic [2*WIDTH-1:0] neg2_fn(input logic [2*WIDTH-1:0] v);
        neg2_fn = ~v + (2*WIDTH)'(1'b1);
    endfunction

    // Magnitude of a signed WIDTH-bit value (most negative maps to itself).
    function automatic logic [WIDTH-1:0] abs_fn(input logic [WIDTH-1:0] v);
        if (v[WIDTH-1]) begin
            abs_fn = neg_fn(v);
        end else begin
            abs_fn = v;
        end
    endfunction

    state_t             state_r;
    state_t             state_nx_s;
    logic [CW-1:0]      cnt_r;
    logic [WIDTH-1:0]   mcand_r;    // multiplicand or divisor magnitude
    logic [2*WIDTH-1:0] prod_r;     // mul: {partial, multiplier}; div: {remainder, quotient}
    logic               neg_lo_r;   // negate product / quotient at commit
    logic               neg_hi_r;   // negate remainder at commit
    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH-1:0]   lo_r;
    logic               busy_r;
    logic               done_r;

    logic               valid_op_s;
    logic               is_mul_s;
    logic               op_signed_s;
    logic               accept_s;
    logic               last_s;
    logic               commit_s;
    logic [WIDTH-1:0]   mag_a_s;
    logic [WIDTH-1:0]   mag_b_s;
    logic [WIDTH:0]     sum_s;
    logic [2*WIDTH-1:0] mul_nx_s;
    logic [WIDTH:0]     shl_s;
    logic [WIDTH:0]     diff_s;
    logic               ge_s;
    logic [2*WIDTH-1:0] div_nx_s;
    logic [2*WIDTH-1:0] prod_fix_s;
    logic [WIDTH-1:0]   res_hi_s;
    logic [WIDTH-1:0]   res_lo_s;

    // Decode the requested operation and the operand magnitudes.
    always_comb begin
        valid_op_s  = 1'b0;
        is_mul_s    = 1'b0;
        op_signed_s = 1'b0;
        case (alucontrol)
            OP_MULT: begin
                valid_op_s  = 1'b1;
                is_mul_s    = 1'b1;
                op_signed_s = 1'b1;
            end
            OP_MULTU: begin
                valid_op_s  = 1'b1;
                is_mul_s    = 1'b1;
            end
            OP_DIV: begin
                valid_op_s  = 1'b1;
                op_signed_s = 1'b1;
            end
            OP_DIVU: begin
                valid_op_s  = 1'b1;
            end
            default: begin
                valid_op_s  = 1'b0;
            end
        endcase
        if (op_signed_s) begin
            mag_a_s = abs_fn(a);
            mag_b_s = abs_fn(b);
        end else begin
            mag_a_s = a;
            mag_b_s = b;
        end
        accept_s = (state_r == ST_IDLE) && start && !flush && valid_op_s;
    end

    // One iteration step for each algorithm, plus the signed result fix-up.
    always_comb begin
        sum_s    = {1'b0, prod_r[2*WIDTH-1:WIDTH]}
                 + (prod_r[0] ? {1'b0, mcand_r} : {(WIDTH+1){1'b0}});
        mul_nx_s = {sum_s, prod_r[WIDTH-1:1]};

        // Restoring divide: shift the next dividend bit into the remainder,
        // subtract the divisor when it fits. A zero divisor always "fits",
        // which yields an all-ones quotient and remainder equal to the dividend.
        shl_s  = {prod_r[2*WIDTH-1:WIDTH], prod_r[WIDTH-1]};
        diff_s = shl_s - {1'b0, mcand_r};
        ge_s   = (shl_s >= {1'b0, mcand_r});
        if (ge_s) begin
            div_nx_s = {diff_s[WIDTH-1:0], prod_r[WIDTH-2:0], 1'b1};
        end else begin
            div_nx_s = {shl_s[WIDTH-1:0], prod_r[WIDTH-2:0], 1'b0};
        end

        last_s = (cnt_r == CW'(WIDTH - 1));

        if (state_r == ST_MUL) begin
            if (neg_lo_r) begin
                prod_fix_s = neg2_fn(mul_nx_s);
            end else begin
                prod_fix_s = mul_nx_s;
            end
            res_hi_s = prod_fix_s[2*WIDTH-1:WIDTH];
            res_lo_s = prod_fix_s[WIDTH-1:0];
        end else begin
            prod_fix_s = div_nx_s;
            if (neg_hi_r) begin
                res_hi_s = neg_fn(div_nx_s[2*WIDTH-1:WIDTH]);
            end else begin
                res_hi_s = div_nx_s[2*WIDTH-1:WIDTH];
            end
            if (neg_lo_r) begin
                res_lo_s = neg_fn(div_nx_s[WIDTH-1:0]);
            end else begin
                res_lo_s = div_nx_s[WIDTH-1:0];
            end
        end

        commit_s = ((state_r == ST_MUL) || (state_r == ST_DIV)) && last_s && !flush;
    end

    // Next-state logic; flush returns to IDLE from anywhere.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nx_s = is_mul_s ? ST_MUL : ST_DIV;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_MUL, ST_DIV: begin
                if (flush) begin
                    state_nx_s = ST_IDLE;
                end else if (last_s) begin
                    state_nx_s = ST_DONE;
                end else begin
                    state_nx_s = state_r;
                end
            end
            ST_DONE: begin
                state_nx_s = ST_IDLE;
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // State register and registered status flags.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            busy_r  <= (state_nx_s != ST_IDLE);
            done_r  <= (state_nx_s == ST_DONE);
        end
    end

    // Working registers: load on accept, step once per cycle while iterating.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_r    <= {CW{1'b0}};
            mcand_r  <= {WIDTH{1'b0}};
            prod_r   <= {(2*WIDTH){1'b0}};
            neg_lo_r <= 1'b0;
            neg_hi_r <= 1'b0;
        end else if (accept_s) begin
            cnt_r   <= {CW{1'b0}};
            mcand_r <= mag_b_s;
            prod_r  <= {{WIDTH{1'b0}}, mag_a_s};
            if (op_signed_s) begin
                // A zero divisor keeps the all-ones quotient unsigned.
                neg_lo_r <= (a[WIDTH-1] ^ b[WIDTH-1]) && (is_mul_s || (b != {WIDTH{1'b0}}));
                neg_hi_r <= a[WIDTH-1] && !is_mul_s;
            end else begin
                neg_lo_r <= 1'b0;
                neg_hi_r <= 1'b0;
            end
        end else if (((state_r == ST_MUL) || (state_r == ST_DIV)) && !flush) begin
            cnt_r  <= cnt_r + CW'(1'b1);
            prod_r <= (state_r == ST_MUL) ? mul_nx_s : div_nx_s;
        end else begin
            cnt_r  <= cnt_r;
            prod_r <= prod_r;
        end
    end

    // HI/LO: result commit, or mthi/mtlo writes while idle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hi_r <= {WIDTH{1'b0}};
            lo_r <= {WIDTH{1'b0}};
        end else if (commit_s) begin
            hi_r <= res_hi_s;
            lo_r <= res_lo_s;
        end else if (state_r == ST_IDLE) begin
            if (hi_we) begin
                hi_r <= hi_wdata;
            end else begin
                hi_r <= hi_r;
            end
            if (lo_we) begin
                lo_r <= lo_wdata;
            end else begin
                lo_r <= lo_r;
            end
        end else begin
            hi_r <= hi_r;
            lo_r <= lo_r;
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign hi   = hi_r;
    assign lo   = lo_r;

endmodule
